sram1r1w_ctrl: RTL and testbench
================================

Name: sram1r1w_ctrl

Overview:
Controller for the 512x64 two-port byte-enabled SRAM macro: port A is the write port and port B is the read port, both clocked by clk.
- After reset it zero-fills every entry.
- It then arbitrates two write requesters round-robin onto port A and serves one reader on port B with a 1-cycle read latency.
- It resolves same-address read/write collisions, which the macro leaves undefined.

Parameters:
DEPTH, 512, number of SRAM entries
ADRBITS, 9, address width (log2 DEPTH)
WIDTH, 64, data width in bits; byte lanes = WIDTH/8
INITVAL, 0, WIDTH-bit value written to every entry during initialization

Ports:
clk  input  1  single clock; also drives macro CLKA/CLKB externally
reset  input  1  asynchronous, active-high reset
InitDone  output  1  high once zero-fill is complete
WrReqA / WrReqB  input  1  write request, requester A / B
WrAdrA / WrAdrB  input  ADRBITS  write address
WrDataA / WrDataB  input  WIDTH  write data
WrBEA / WrBEB  input  WIDTH/8  byte enables, active-high
WrGntA / WrGntB  output  1  write accepted this cycle
RdReq  input  1  read request
RdAdr  input  ADRBITS  read address
RdGnt  output  1  read accepted this cycle
RdValid  output  1  RdData valid; pulses 1 cycle after RdGnt
RdData  output  WIDTH  read data
CEBA, WEBA  output  1  macro port A chip/write enables, active-low
AA  output  ADRBITS  macro port A address
DA  output  WIDTH  macro port A write data
BWEBA  output  WIDTH  macro port A bit write enables, active-low
CEBB, WEBB  output  1  macro port B chip/write enables, active-low
AB  output  ADRBITS  macro port B address
DB  output  WIDTH  macro port B data; tied 0
BWEBB  output  WIDTH  macro port B bit write enables; tied all-ones
QB  input  WIDTH  macro port B read data, valid 1 cycle after access

Behaviour:
- Reset (asynchronous): state=INIT, InitCnt=0, LastGnt=B (so A wins the first tie), InitDone=0, RdValid=0, registered read-side state=0.
- Reset outputs: WrGntA/B=0, RdGnt=0, CEBA=0 (INIT write active), CEBB=1, WEBB=1.
- States: INIT -> RUN. RUN is exited only by reset.

INIT:
- Each cycle: CEBA=0, WEBA=0, AA=InitCnt, DA=INITVAL, BWEBA=all 0. InitCnt increments.
- At InitCnt=DEPTH-1 the next state is RUN. InitDone goes 1 on that edge, exactly DEPTH cycles after reset release.
- All grants are 0. CEBB=1.

RUN, write arbitration (combinational grant, same cycle):
- Only one requester active: that requester is granted.
- Both active: the requester not equal to LastGnt is granted.
- LastGnt updates on each grant.
- When a write is granted: CEBA=0, WEBA=0, AA/DA from the granted requester, BWEBA[8i+7:8i]=~WrBE[i].
- No write granted: CEBA=1, WEBA=1. AA/DA hold their last values; no toggling is required.
- A requester holds its request, address, data and byte enables until granted.
- A granted write with all byte enables 0 is still granted; the macro cell contents are unchanged.

RUN, read:
- RdGnt = RdReq, except when blocked by a collision (see below).
- On RdGnt: CEBB=0, WEBB=1, AB=RdAdr.
- RdValid is registered to 1 on the next cycle, with RdData=QB.
- Back-to-back reads are allowed, giving one result per cycle.
- Without a read this cycle: CEBB=1 and RdValid falls next cycle. RdData holds its last value.

Collision (same cycle, RdReq, a write granted, RdAdr==granted write address):
- Handled according to the optional feature below.

Reset mid-operation:
- Any pending RdValid is dropped and the FSM returns to INIT.
- The array is re-zeroed; in-flight requests are discarded without grant.

Optional Feature:
Macro SRAM_RAW_BYPASS_EN.
- Defined: a colliding read is granted. The controller registers the write data and byte enables. Next cycle, RdData is the byte-wise merge of that registered data: written bytes come from the new write data, all other bytes from QB. Read throughput is unaffected.
- Undefined: on collision RdGnt=0 and CEBB=1. The reader retries and is served the following cycle with the post-write data. The write is never delayed.

Test Plan:
- Reset release -> exactly 512 port-A writes with AA=0..511, DA=0, BWEBA=0. InitDone rises on cycle 512. A read of adr 0x1FF then returns 0.
- Write A: adr 0x010, data 0x1122334455667788, BE=0xFF; then a read of 0x010 -> RdValid 1 cycle after RdGnt, RdData=0x1122334455667788.
- WrReqA and WrReqB held high for 4 cycles -> grants alternate A,B,A,B starting with A. With WrReqB alone -> WrGntB every cycle.
- Partial write BE=0x0F, data 0xFFFFFFFF_AAAAAAAA, to an entry holding 0x1122334455667788 -> the read returns 0x11223344_AAAAAAAA.
- Same-cycle write and read to adr 0x020 (old 0, new 0xDEADBEEF_00000000, BE=0xF0):
  - With SRAM_RAW_BYPASS_EN: RdGnt=1, and next cycle RdData=0xDEADBEEF_00000000.
  - Without it: RdGnt=0, the retry is granted next cycle and returns the same value.
- reset asserted for 1 cycle during RUN, with reads in flight -> RdValid=0 immediately, InitDone=0. Re-zero takes 512 cycles; prior data reads back 0.

Source files
------------

// File: rtl/sram1r1w_ctrl.sv
// sram1r1w_ctrl: 512x64 1R1W SRAM controller, zero-fill init, RR write arbiter.
// Optional same-address read-after-write bypass: SRAM_RAW_BYPASS_EN.
module sram1r1w_ctrl #(
  parameter int DEPTH   = 512,
  parameter int ADRBITS = 9,
  parameter int WIDTH   = 64,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 InitDone,
  input  logic                 WrReqA,
  input  logic [ADRBITS-1:0]   WrAdrA,
  input  logic [WIDTH-1:0]     WrDataA,
  input  logic [WIDTH/8-1:0]   WrBEA,
  output logic                 WrGntA,
  input  logic                 WrReqB,
  input  logic [ADRBITS-1:0]   WrAdrB,
  input  logic [WIDTH-1:0]     WrDataB,
  input  logic [WIDTH/8-1:0]   WrBEB,
  output logic                 WrGntB,
  input  logic                 RdReq,
  input  logic [ADRBITS-1:0]   RdAdr,
  output logic                 RdGnt,
  output logic                 RdValid,
  output logic [WIDTH-1:0]     RdData,
  output logic                 CEBA,
  output logic                 WEBA,
  output logic [ADRBITS-1:0]   AA,
  output logic [WIDTH-1:0]     DA,
  output logic [WIDTH-1:0]     BWEBA,
  output logic                 CEBB,
  output logic                 WEBB,
  output logic [ADRBITS-1:0]   AB,
  output logic [WIDTH-1:0]     DB,
  output logic [WIDTH-1:0]     BWEBB,
  input  logic [WIDTH-1:0]     QB
);

  localparam int NB = WIDTH / 8;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ADRBITS-1:0] init_cnt_q, init_cnt_d;
  logic               last_b_q, last_b_d;
  logic [ADRBITS-1:0] aa_q;
  logic [WIDTH-1:0]   da_q;
  logic               rd_valid_q;
  logic [WIDTH-1:0]   rd_hold_q;

  logic               run;
  logic               gnt_a;
  logic               gnt_b;
  logic               wr_gnt;
  logic               coll;
  logic               rd_gnt;
  logic [ADRBITS-1:0] w_adr;
  logic [WIDTH-1:0]   w_data;
  logic [NB-1:0]      w_be;
  logic [WIDTH-1:0]   be_mask;
  logic [WIDTH-1:0]   rd_data;

  assign run = (state_q == S_RUN);

  // last_b_q set means B won last, so A wins the next tie
  assign gnt_a  = run & WrReqA & (~WrReqB | last_b_q);
  assign gnt_b  = run & WrReqB & ~gnt_a;
  assign wr_gnt = gnt_a | gnt_b;

  assign w_adr  = gnt_a ? WrAdrA  : WrAdrB;
  assign w_data = gnt_a ? WrDataA : WrDataB;
  assign w_be   = gnt_a ? WrBEA   : WrBEB;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NB; i++) begin
      be_mask[8*i +: 8] = {8{w_be[i]}};
    end
  end

  assign coll = RdReq & wr_gnt & (RdAdr == w_adr);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    last_b_d   = last_b_q;
    if (!run) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ADRBITS'(DEPTH - 1)) begin
        state_d = S_RUN;
      end
    end else if (gnt_a) begin
      last_b_d = 1'b0;
    end else if (gnt_b) begin
      last_b_d = 1'b1;
    end
  end

  always_comb begin
    CEBA  = 1'b1;
    WEBA  = 1'b1;
    AA    = aa_q;
    DA    = da_q;
    BWEBA = '1;
    if (!run) begin
      CEBA  = 1'b0;
      WEBA  = 1'b0;
      AA    = init_cnt_q;
      DA    = INITVAL;
      BWEBA = '0;
    end else if (wr_gnt) begin
      CEBA  = 1'b0;
      WEBA  = 1'b0;
      AA    = w_adr;
      DA    = w_data;
      BWEBA = ~be_mask;
    end
  end

`ifdef SRAM_RAW_BYPASS_EN
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;
  logic [WIDTH-1:0] byp_mask_q;

  assign rd_gnt = run & RdReq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else begin
      byp_q      <= coll;
      byp_data_q <= w_data;
      byp_mask_q <= be_mask;
    end
  end

  // macro returns pre-write data; overlay the bytes written that cycle
  assign rd_data = byp_q ? ((QB & ~byp_mask_q) | (byp_data_q & byp_mask_q))
                         : QB;
`else
  assign rd_gnt  = run & RdReq & ~coll;
  assign rd_data = QB;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      last_b_q   <= 1'b1;
      aa_q       <= '0;
      da_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      last_b_q   <= last_b_d;
      aa_q       <= AA;
      da_q       <= DA;
      rd_valid_q <= rd_gnt;
      if (rd_valid_q) begin
        rd_hold_q <= rd_data;
      end
    end
  end

  assign InitDone = run;
  assign WrGntA   = gnt_a;
  assign WrGntB   = gnt_b;
  assign RdGnt    = rd_gnt;
  assign RdValid  = rd_valid_q;
  assign RdData   = rd_valid_q ? rd_data : rd_hold_q;
  assign CEBB     = ~rd_gnt;
  assign WEBB     = 1'b1;
  assign AB       = RdAdr;
  assign DB       = '0;
  assign BWEBB    = '1;

endmodule

// File: tb/tb_sram1r1w_ctrl.sv
// tb_sram1r1w_ctrl: directed table, randomized traffic vs. a memory-level
// reference model, and mid-run reset for sram1r1w_ctrl.
module tb_sram1r1w_ctrl;

  localparam int D = 512;

`ifdef SRAM_RAW_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        InitDone;
  logic        WrReqA, WrReqB, RdReq;
  logic [8:0]  WrAdrA, WrAdrB, RdAdr;
  logic [63:0] WrDataA, WrDataB;
  logic [7:0]  WrBEA, WrBEB;
  logic        WrGntA, WrGntB, RdGnt, RdValid;
  logic [63:0] RdData;
  logic        CEBA, WEBA, CEBB, WEBB;
  logic [8:0]  AA, AB;
  logic [63:0] DA, BWEBA, DB, BWEBB, QB;

  always #5 clk = ~clk;

  sram1r1w_ctrl dut (
    .clk(clk), .reset(reset), .InitDone(InitDone),
    .WrReqA(WrReqA), .WrAdrA(WrAdrA), .WrDataA(WrDataA),
    .WrBEA(WrBEA), .WrGntA(WrGntA),
    .WrReqB(WrReqB), .WrAdrB(WrAdrB), .WrDataB(WrDataB),
    .WrBEB(WrBEB), .WrGntB(WrGntB),
    .RdReq(RdReq), .RdAdr(RdAdr), .RdGnt(RdGnt),
    .RdValid(RdValid), .RdData(RdData),
    .CEBA(CEBA), .WEBA(WEBA), .AA(AA), .DA(DA), .BWEBA(BWEBA),
    .CEBB(CEBB), .WEBB(WEBB), .AB(AB), .DB(DB), .BWEBB(BWEBB),
    .QB(QB)
  );

  // macro model: read-before-write on port B, bit-masked write on port A
  logic [63:0] mem [D];
  always @(posedge clk) begin
    if (!CEBB) QB <= mem[AB];
    if (!CEBA && !WEBA) mem[AA] <= (mem[AA] & BWEBA) | (DA & ~BWEBA);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // reference: architectural memory contents and round-robin pointer
  logic [63:0] ref_mem [D];
  bit          last_b;

  function automatic logic [63:0] bemask(input logic [7:0] be);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o,
                                        input logic [63:0] n,
                                        input logic [7:0] be);
    return (o & ~bemask(be)) | (n & bemask(be));
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    last_b = 1'b1;
  endtask

  task automatic idle_inputs();
    WrReqA = 0; WrReqB = 0; RdReq = 0;
    WrAdrA = '0; WrAdrB = '0; RdAdr = '0;
    WrDataA = '0; WrDataB = '0; WrBEA = '0; WrBEB = '0;
  endtask

  // called at the negedge reset is released
  task automatic init_check();
    int bad = 0;
    int nz = 0;
    WrReqA = 1; WrReqB = 1; RdReq = 1;
    for (int k = 0; k < D; k++) begin
      #1;
      if (AA !== 9'(k) || DA !== '0 || BWEBA !== '0 || CEBA || WEBA ||
          WrGntA || WrGntB || RdGnt || !CEBB || InitDone) bad++;
      @(negedge clk);
    end
    idle_inputs();
    chk("init_seq_errs", 64'(bad), 64'd0);
    #1;
    chk("init_done", 64'(InitDone), 64'd1);
    for (int i = 0; i < D; i++) if (mem[i] !== '0) nz++;
    chk("init_fill_nonzero", 64'(nz), 64'd0);
  endtask

  task automatic read_check(input string nm, input logic [8:0] a,
                            input logic [63:0] exp);
    @(negedge clk);
    RdReq = 1; RdAdr = a;
    #1;
    chk({nm, "_gnt"}, 64'(RdGnt), 64'd1);
    @(negedge clk);
    RdReq = 0;
    #1;
    chk({nm, "_valid"}, 64'(RdValid), 64'd1);
    chk({nm, "_data"}, RdData, exp);
  endtask

  typedef struct {
    logic ra; logic [8:0] aa; logic [63:0] da; logic [7:0] ba;
    logic rb; logic [8:0] ab; logic [63:0] db; logic [7:0] bb;
    logic rd; logic [8:0] radr;
    logic ega, egb, erg, erv; logic [63:0] erd;
  } vec_t;

  function automatic vec_t mk(
    input logic ra, input logic [8:0] aa, input logic [63:0] da,
    input logic [7:0] ba,
    input logic rb, input logic [8:0] ab, input logic [63:0] db,
    input logic [7:0] bb,
    input logic rd, input logic [8:0] radr,
    input logic ega, input logic egb, input logic erg, input logic erv,
    input logic [63:0] erd);
    vec_t v;
    v.ra = ra; v.aa = aa; v.da = da; v.ba = ba;
    v.rb = rb; v.ab = ab; v.db = db; v.bb = bb;
    v.rd = rd; v.radr = radr;
    v.ega = ega; v.egb = egb; v.erg = erg; v.erv = erv; v.erd = erd;
    return v;
  endfunction

  localparam logic [63:0] DB0 = 64'hB0B0B0B0_B0B0B0B0;
  localparam logic [63:0] D12 = 64'h12121212_12121212;
  localparam logic [63:0] D13 = 64'h13131313_13131313;
  localparam logic [63:0] D14 = 64'h14141414_14141414;
  localparam logic [63:0] DW  = 64'h11223344_55667788;
  localparam logic [63:0] DP  = 64'hFFFFFFFF_AAAAAAAA;
  localparam logic [63:0] DM  = 64'h11223344_AAAAAAAA;
  localparam logic [63:0] DC  = 64'hDEADBEEF_00000000;

  vec_t tbl [22];

  initial begin
    logic        pa, pb, pr, exp_rv;
    logic [8:0]  pa_adr, pb_adr, pr_adr, wadr;
    logic [63:0] pa_dat, pb_dat, exp_rd, wdat;
    logic [7:0]  pa_be, pb_be, wbe;
    logic        ega, egb, erg, colls;

    tbl[0]  = mk(1, 9'h010, DW, 8'hFF, 1, 9'h011, DB0, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 9'h012, D12, 8'hFF, 1, 9'h011, DB0, 8'hFF, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 9'h012, D12, 8'hFF, 1, 9'h013, D13, 8'hFF, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 9'h014, D14, 8'hFF, 1, 9'h013, D13, 8'hFF, 0, 0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 9'h014, D14, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 9'h015, D13, 8'hFF, 0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1, 9'h016, D14, 8'h3C, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h010, 0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DW);
    tbl[9]  = mk(1, 9'h010, DP, 8'h0F, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h010, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DM);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h1FF, 0, 0, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(1, 9'h020, DC, 8'hF0, 0, 0, 0, 0, 1, 9'h020, 1, 0, BYP, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h020, 0, 0, 1, BYP, DC);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DC);
    tbl[17] = mk(1, 9'h010, '1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h010, 0, 0, 1, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DM);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9'h016, 0, 0, 1, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h00001414_14140000);

    for (int i = 0; i < D; i++) mem[i] = {32'hA5A5A5A5, 32'(i)};
    QB = '0;
    idle_inputs();
    clear_ref();
    reset = 1;
    repeat (3) @(negedge clk);
    WrReqA = 1; WrReqB = 1; RdReq = 1;
    #1;
    chk("rst_initdone", 64'(InitDone), 64'd0);
    chk("rst_rdvalid", 64'(RdValid), 64'd0);
    chk("rst_grants", {61'd0, WrGntA, WrGntB, RdGnt}, 64'd0);
    chk("rst_ceba_cebb_webb", {61'd0, CEBA, CEBB, WEBB}, 64'd3);
    @(negedge clk);
    reset = 0;
    init_check();

    // directed table
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      WrReqA = tbl[i].ra; WrAdrA = tbl[i].aa;
      WrDataA = tbl[i].da; WrBEA = tbl[i].ba;
      WrReqB = tbl[i].rb; WrAdrB = tbl[i].ab;
      WrDataB = tbl[i].db; WrBEB = tbl[i].bb;
      RdReq = tbl[i].rd; RdAdr = tbl[i].radr;
      #1;
      chk($sformatf("tbl%0d_gnt", i), {62'd0, WrGntA, WrGntB},
          {62'd0, tbl[i].ega, tbl[i].egb});
      chk($sformatf("tbl%0d_rdgnt", i), 64'(RdGnt), 64'(tbl[i].erg));
      chk($sformatf("tbl%0d_rdvalid", i), 64'(RdValid), 64'(tbl[i].erv));
      if (tbl[i].erv)
        chk($sformatf("tbl%0d_rddata", i), RdData, tbl[i].erd);
      if (tbl[i].ega || tbl[i].egb) begin
        wadr = tbl[i].ega ? tbl[i].aa : tbl[i].ab;
        wdat = tbl[i].ega ? tbl[i].da : tbl[i].db;
        wbe  = tbl[i].ega ? tbl[i].ba : tbl[i].bb;
        chk($sformatf("tbl%0d_portA", i), {53'd0, CEBA, WEBA, AA},
            {53'd0, 2'b00, wadr});
        chk($sformatf("tbl%0d_DA", i), DA, wdat);
        chk($sformatf("tbl%0d_BWEBA", i), BWEBA, ~bemask(wbe));
        ref_mem[wadr] = merge(ref_mem[wadr], wdat, wbe);
        last_b = tbl[i].egb;
      end else begin
        chk($sformatf("tbl%0d_ceba_idle", i), 64'(CEBA), 64'd1);
      end
      if (tbl[i].erg)
        chk($sformatf("tbl%0d_portB", i), {54'd0, CEBB, AB},
            {54'd0, 1'b0, tbl[i].radr});
      else
        chk($sformatf("tbl%0d_cebb_idle", i), 64'(CEBB), 64'd1);
      @(negedge clk);
    end
    idle_inputs();

    // randomized traffic on a small address window to force collisions
    pa = 0; pb = 0; pr = 0; exp_rv = 0; exp_rd = '0; colls = 0;
    pa_adr = '0; pb_adr = '0; pr_adr = '0;
    pa_dat = '0; pb_dat = '0; pa_be = '0; pb_be = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!pa && $urandom_range(2, 0) != 0) begin
        pa = 1; pa_adr = 9'($urandom_range(7, 0));
        pa_dat = {$urandom, $urandom}; pa_be = 8'($urandom);
      end
      if (!pb && $urandom_range(2, 0) != 0) begin
        pb = 1; pb_adr = 9'($urandom_range(7, 0));
        pb_dat = {$urandom, $urandom}; pb_be = 8'($urandom);
      end
      if (!pr && $urandom_range(3, 0) != 0) begin
        pr = 1; pr_adr = 9'($urandom_range(7, 0));
      end
      WrReqA = pa; WrAdrA = pa_adr; WrDataA = pa_dat; WrBEA = pa_be;
      WrReqB = pb; WrAdrB = pb_adr; WrDataB = pb_dat; WrBEB = pb_be;
      RdReq = pr; RdAdr = pr_adr;
      #1;
      ega = pa && (!pb || last_b);
      egb = pb && !ega;
      wadr = ega ? pa_adr : pb_adr;
      wdat = ega ? pa_dat : pb_dat;
      wbe  = ega ? pa_be : pb_be;
      colls = pr && (ega || egb) && (pr_adr == wadr);
      erg = pr && (BYP || !colls);
      chk($sformatf("rnd%0d_gnt", c),
          {61'd0, WrGntA, WrGntB, RdGnt}, {61'd0, ega, egb, erg});
      chk($sformatf("rnd%0d_rdvalid", c), 64'(RdValid), 64'(exp_rv));
      if (exp_rv) chk($sformatf("rnd%0d_rddata", c), RdData, exp_rd);
      chk($sformatf("rnd%0d_ceba", c), 64'(CEBA), 64'(!(ega || egb)));
      if (ega || egb) begin
        ref_mem[wadr] = merge(ref_mem[wadr], wdat, wbe);
        last_b = egb;
      end
      if (ega) pa = 0;
      if (egb) pb = 0;
      exp_rv = erg;
      if (erg) begin
        exp_rd = ref_mem[pr_adr];
        pr = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("rnd_tail_rdvalid", 64'(RdValid), 64'(exp_rv));
    if (exp_rv) chk("rnd_tail_rddata", RdData, exp_rd);

    // reset during RUN with a read result on the bus
    read_check("pre_rst_rd", 9'h010, ref_mem[9'h010]);
    #1;
    reset = 1;
    #1;
    chk("midrst_rdvalid", 64'(RdValid), 64'd0);
    chk("midrst_initdone", 64'(InitDone), 64'd0);
    chk("midrst_ceba", 64'(CEBA), 64'd0);
    @(negedge clk);
    reset = 0;
    clear_ref();
    init_check();
    read_check("post_rst_010", 9'h010, 64'd0);
    read_check("post_rst_020", 9'h020, 64'd0);
    read_check("post_rst_1ff", 9'h1FF, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
